filter2d_ctrl: RTL

- Run-sequencer for the filter2d engine.
- Holds a shadow copy of the 9 filter coefficients and programs them into the engine over its h_write/h_idx/h_data port before each frame.
- Issues the start pulse, waits for finish with a timeout watchdog, and repeats for a programmed number of frames.
- Sits between the host/config logic and filter2d; the memory buffer is untouched by this block.

---
 rtl/filter2d_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/filter2d_ctrl.sv
// filter2d_ctrl: run-sequencer for the filter2d engine.
// Keeps a shadow copy of the NTAP filter coefficients. Before every frame it
// streams them into the engine, then pulses f_start and waits for f_finish
// under a timeout watchdog. This repeats for num_frames frames.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   cfg_we/cfg_idx/cfg_data          shadow coefficient write port
//   run/num_frames/abort             run control from the host
//   busy (comb), done, err_timeout,  run status
//   frames_done
//   f_start, f_h_write/f_h_idx/      engine control and coefficient load
//   f_h_data, f_finish
module filter2d_ctrl #(
  parameter int unsigned NTAP        = 9,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYC = 1048576,
  parameter int unsigned TW          = 21
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_we,
  input  logic [3:0] cfg_idx,
  input  logic [7:0] cfg_data,
  input  logic       run,
  input  logic [7:0] num_frames,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic [7:0] frames_done,
  output logic       f_start,
  output logic       f_h_write,
  output logic [3:0] f_h_idx,
  output logic [7:0] f_h_data,
  input  logic       f_finish
);

  localparam int unsigned IW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned FW = 8;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] k_q, k_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [FW-1:0] tgt_q, tgt_d;
  logic [FW-1:0] fd_q, fd_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          start_q, start_d;
  logic          hw_q, hw_d;
  logic [IW-1:0] hidx_q, hidx_d;
  logic [DW-1:0] hdata_q, hdata_d;
  logic [DW-1:0] shadow_q [NTAP];
  logic          cfg_wr_ok;

  // Indices at or above NTAP have no shadow entry and are dropped.
  assign cfg_wr_ok = cfg_we && ({1'b0, cfg_idx} < 5'(NTAP));

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    tgt_d   = tgt_q;
    fd_d    = fd_q;
    err_d   = err_q;
    done_d  = 1'b0;
    start_d = 1'b0;
    hw_d    = 1'b0;
    hidx_d  = '0;
    hdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          tgt_d = num_frames;
          fd_d  = '0;
          err_d = 1'b0;
          if (num_frames == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            k_d     = '0;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (k_q == IW'(NTAP - 1)) begin
          state_d = S_START;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_START: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end
      end
      S_WAIT: begin
        // Priority: abort, then finish, then the timeout limit.
        if (abort) begin
          state_d = S_IDLE;
        end else if (f_finish) begin
          fd_d = fd_q + FW'(1);
          if (fd_q + FW'(1) == tgt_q) begin
            state_d = S_DONE;
          end else if (GAP_CYCLES == 0) begin
            state_d = S_LOAD;
            k_d     = '0;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (32'(gap_q) + 32'd1 >= GAP_CYCLES) begin
          state_d = S_LOAD;
          k_d     = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered, so derive them from the state being entered.
    done_d  = (state_d == S_DONE);
    start_d = (state_d == S_START);
    if (state_d == S_LOAD) begin
      hw_d   = 1'b1;
      hidx_d = k_d;
      // Forward a same-cycle config write so it reaches this beat.
      if (cfg_we && (cfg_idx == k_d)) begin
        hdata_d = cfg_data;
      end else begin
        hdata_d = shadow_q[k_d];
      end
    end
  end

  // State, counters, outputs and shadow coefficients.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      tgt_q   <= '0;
      fd_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      hw_q    <= 1'b0;
      hidx_q  <= '0;
      hdata_q <= '0;
      for (int i = 0; i < int'(NTAP); i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      tgt_q   <= tgt_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
      done_q  <= done_d;
      start_q <= start_d;
      hw_q    <= hw_d;
      hidx_q  <= hidx_d;
      hdata_q <= hdata_d;
      if (cfg_wr_ok) begin
        shadow_q[cfg_idx] <= cfg_data;
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err_timeout = err_q;
  assign frames_done = fd_q;
  assign f_start     = start_q;
  assign f_h_write   = hw_q;
  assign f_h_idx     = hidx_q;
  assign f_h_data    = hdata_q;

endmodule
